// File: rtl/mem_arbiter_pkg.sv
//------------------------------------------------------------------------------
// Module   : mem_arbiter_pkg
// Brief    : Shared FSM encodings, latency bounds and port-select codes.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
package mem_arbiter_pkg;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_WAIT  = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    localparam int c_LAT_MIN = 1;
    localparam int c_LAT_MAX = 15;

    // Wide enough to hold c_LAT_MAX.
    localparam int                 c_CNT_W   = 4;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = 4'd1;

    localparam logic c_SEL_FETCH = 1'b0;
    localparam logic c_SEL_DATA  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_arb_select.sv
//------------------------------------------------------------------------------
// Module   : mem_arb_select
// Brief    : Fixed-priority winner pick (data over fetch) and operand mux.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
module mem_arb_select
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_fetch_req,
    input  logic [ADDR_WIDTH-1:0] i_fetch_addr,
    input  logic                  i_data_req,
    input  logic                  i_data_we,
    input  logic [ADDR_WIDTH-1:0] i_data_addr,
    input  logic [DATA_WIDTH-1:0] i_data_wdata,
    output logic                  o_grant,
    output logic                  o_sel,
    output logic                  o_we,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [DATA_WIDTH-1:0] o_wdata
);

    always_comb begin
        o_grant = i_fetch_req | i_data_req;
        o_sel   = i_data_req ? c_SEL_DATA : c_SEL_FETCH;
        o_we    = i_data_req & i_data_we;
        o_addr  = i_data_req ? i_data_addr : i_fetch_addr;
        o_wdata = i_data_req ? i_data_wdata : '0;
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
//------------------------------------------------------------------------------
// Module   : mem_arbiter
// Brief    : Serialises CPU fetch and data accesses onto one fixed-latency
//            single-port memory. Define MEM_ARB_CONFLICT_COUNT_EN to build
//            the saturating conflict counter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_done,
    output logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_done,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [31:0]           conflicts
);

    localparam logic [c_CNT_W-1:0] c_LAT_LOAD = MEM_LATENCY[c_CNT_W-1:0];

    if (MEM_LATENCY < c_LAT_MIN || MEM_LATENCY > c_LAT_MAX) begin : g_bad_latency
        $error("mem_arbiter: MEM_LATENCY must be within 1..15");
    end

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic                  r_sel;
    logic                  r_we;
    logic [c_CNT_W-1:0]    r_cnt;
    logic                  r_mem_en;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic                  r_i_done;
    logic                  r_d_done;
    logic [DATA_WIDTH-1:0] r_i_rdata;
    logic [DATA_WIDTH-1:0] r_d_rdata;

    logic                  w_grant;
    logic                  w_sel;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;

    mem_arb_select #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_select (
        .i_fetch_req  (i_req),
        .i_fetch_addr (i_addr),
        .i_data_req   (d_req),
        .i_data_we    (d_we),
        .i_data_addr  (d_addr),
        .i_data_wdata (d_wdata),
        .o_grant      (w_grant),
        .o_sel        (w_sel),
        .o_we         (w_we),
        .o_addr       (w_addr),
        .o_wdata      (w_wdata)
    );

    always_ff @(posedge clock) begin
        if (!reset) r_state <= c_ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_grant) w_state_nxt = c_ST_ISSUE;
            c_ST_ISSUE: w_state_nxt = c_ST_WAIT;
            c_ST_WAIT:  if (r_cnt == c_CNT_ONE) w_state_nxt = c_ST_DONE;
            c_ST_DONE:  w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Every output is a register; strobes and pulses default low each cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_sel       <= c_SEL_FETCH;
            r_we        <= 1'b0;
            r_cnt       <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_i_done    <= 1'b0;
            r_d_done    <= 1'b0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
        end else begin
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            r_i_done <= 1'b0;
            r_d_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_grant) begin
                        r_sel       <= w_sel;
                        r_we        <= w_we;
                        r_mem_addr  <= w_addr;
                        r_mem_wdata <= w_wdata;
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= w_we;
                    end
                end
                c_ST_ISSUE: r_cnt <= c_LAT_LOAD;
                c_ST_WAIT: begin
                    r_cnt <= r_cnt - c_CNT_ONE;
                    if (r_cnt == c_CNT_ONE) begin
                        if (r_sel == c_SEL_DATA) begin
                            r_d_done <= 1'b1;
                            if (!r_we) r_d_rdata <= mem_rdata;
                        end else begin
                            r_i_done  <= 1'b1;
                            r_i_rdata <= mem_rdata;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign i_done    = r_i_done;
    assign d_done    = r_d_done;
    assign i_rdata   = r_i_rdata;
    assign d_rdata   = r_d_rdata;

`ifdef MEM_ARB_CONFLICT_COUNT_EN
    logic [31:0] r_conflicts;

    always_ff @(posedge clock) begin
        if (!reset)
            r_conflicts <= '0;
        else if (r_state == c_ST_IDLE && i_req && d_req && r_conflicts != 32'hFFFF_FFFF)
            r_conflicts <= r_conflicts + 32'd1;
    end

    assign conflicts = r_conflicts;
`else
    assign conflicts = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_mem_arbiter
// Brief    : Self-checking bench for mem_arbiter at latencies 2, 1 and 7.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none
module tb_mem_arbiter;

    localparam int N = 3;

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 7);
    endfunction

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic        i_req     [N];
    logic [31:0] i_addr    [N];
    logic        i_done    [N];
    logic [31:0] i_rdata   [N];
    logic        d_req     [N];
    logic        d_we      [N];
    logic [31:0] d_addr    [N];
    logic [31:0] d_wdata   [N];
    logic        d_done    [N];
    logic [31:0] d_rdata   [N];
    logic        mem_en    [N];
    logic        mem_we    [N];
    logic [31:0] mem_addr  [N];
    logic [31:0] mem_wdata [N];
    logic [31:0] mem_rdata [N];
    logic [31:0] conflicts [N];

    logic [31:0] mem     [N][256];
    logic [31:0] ref_mem [N][256];
    logic [3:0]  mcnt [N];
    logic [7:0]  midx [N];
    logic        pl_en;
    logic [7:0]  pl_idx;
    logic [31:0] pl_data;

    int n_pass  = 0;
    int n_total = 0;

    // Memory model: read data is valid only in the cycle exactly LAT after mem_en.
    always @(posedge clock) begin
        for (int k = 0; k < N; k++) begin
            if (pl_en) mem[k][pl_idx] <= pl_data;
            if (!reset) begin
                mcnt[k] <= 4'd0;
            end else if (mem_en[k]) begin
                if (mem_we[k]) mem[k][mem_addr[k][9:2]] <= mem_wdata[k];
                mcnt[k] <= 4'(lat_of(k));
                midx[k] <= mem_addr[k][9:2];
            end else if (mcnt[k] != 4'd0) begin
                mcnt[k] <= mcnt[k] - 4'd1;
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_dut
        assign mem_rdata[g] = (mcnt[g] == 4'd1) ? mem[g][midx[g]] : 32'hA5A5_5A5A;

        mem_arbiter #(
            .ADDR_WIDTH  (32),
            .DATA_WIDTH  (32),
            .MEM_LATENCY (lat_of(g))
        ) u_dut (
            .clock     (clock),
            .reset     (reset),
            .i_req     (i_req[g]),
            .i_addr    (i_addr[g]),
            .i_done    (i_done[g]),
            .i_rdata   (i_rdata[g]),
            .d_req     (d_req[g]),
            .d_we      (d_we[g]),
            .d_addr    (d_addr[g]),
            .d_wdata   (d_wdata[g]),
            .d_done    (d_done[g]),
            .d_rdata   (d_rdata[g]),
            .mem_en    (mem_en[g]),
            .mem_we    (mem_we[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_rdata (mem_rdata[g]),
            .conflicts (conflicts[g])
        );
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        for (int k = 0; k < N; k++) begin
            i_req[k] = 1'b0; i_addr[k] = '0; d_req[k] = 1'b0; d_we[k] = 1'b0;
            d_addr[k] = '0; d_wdata[k] = '0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clear_inputs();
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic preload();
        for (int i = 0; i < 256; i++) begin
            pl_en = 1'b1; pl_idx = 8'(i);
            pl_data = (i == 16) ? 32'h8C08_0004 : $urandom();
            for (int k = 0; k < N; k++) ref_mem[k][i] = pl_data;
            tick();
        end
        pl_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        i_req[0] = 1'b1; d_req[0] = 1'b1; i_addr[0] = 32'h40; d_addr[0] = 32'h80;
        tick();
        tick();
        for (int k = 0; k < N; k++) begin
            n_total++;
            if ({mem_en[k], mem_we[k], i_done[k], d_done[k]} !== 4'b0 || mem_addr[k] !== 32'h0 ||
                mem_wdata[k] !== 32'h0 || i_rdata[k] !== 32'h0 || d_rdata[k] !== 32'h0 || conflicts[k] !== 32'h0)
                $display("FAIL reset_state[%0d]: got en=%0b we=%0b id=%0b dd=%0b addr=%h wd=%h ird=%h drd=%h conf=%0d expected all zero",
                         k, mem_en[k], mem_we[k], i_done[k], d_done[k], mem_addr[k], mem_wdata[k], i_rdata[k], d_rdata[k], conflicts[k]);
            else n_pass++;
        end
        clear_inputs();
        reset = 1'b1;
    endtask

    task automatic test_lone_fetch();
        do_reset();
        i_req[0] = 1'b1; i_addr[0] = 32'h40;
        tick();
        n_total++;
        if (mem_en[0] !== 1'b1 || mem_we[0] !== 1'b0 || mem_addr[0] !== 32'h40)
            $display("FAIL fetch_issue: got en=%0b we=%0b addr=%h expected en=1 we=0 addr=00000040", mem_en[0], mem_we[0], mem_addr[0]);
        else n_pass++;
        tick();
        n_total++;
        if (mem_en[0] !== 1'b0) $display("FAIL fetch_en_width: got en=%0b expected 0", mem_en[0]); else n_pass++;
        tick();
        n_total++;
        if (i_done[0] !== 1'b0) $display("FAIL fetch_early_done: got %0b expected 0", i_done[0]); else n_pass++;
        tick();
        n_total++;
        if (i_done[0] !== 1'b1 || d_done[0] !== 1'b0 || i_rdata[0] !== 32'h8C08_0004)
            $display("FAIL fetch_done: got id=%0b dd=%0b rdata=%h expected id=1 dd=0 rdata=8c080004", i_done[0], d_done[0], i_rdata[0]);
        else n_pass++;
        i_req[0] = 1'b0;
        tick();
        n_total++;
        if (i_done[0] !== 1'b0) $display("FAIL fetch_done_pulse: got %0b expected 0", i_done[0]); else n_pass++;
    endtask

    task automatic test_write_read();
        logic [31:0] prev;
        do_reset();
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h200;
        repeat (4) tick();
        prev = ref_mem[0][128];
        n_total++;
        if (d_done[0] !== 1'b1 || d_rdata[0] !== prev)
            $display("FAIL wr_preread: got dd=%0b rdata=%h expected dd=1 rdata=%h", d_done[0], d_rdata[0], prev);
        else n_pass++;
        d_req[0] = 1'b0;
        tick();
        d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'h100; d_wdata[0] = 32'hDEAD_BEEF;
        tick();
        n_total++;
        if (mem_en[0] !== 1'b1 || mem_we[0] !== 1'b1 || mem_addr[0] !== 32'h100 || mem_wdata[0] !== 32'hDEAD_BEEF)
            $display("FAIL write_issue: got en=%0b we=%0b addr=%h wd=%h expected 1 1 00000100 deadbeef",
                     mem_en[0], mem_we[0], mem_addr[0], mem_wdata[0]);
        else n_pass++;
        repeat (3) tick();
        n_total++;
        if (d_done[0] !== 1'b1 || d_rdata[0] !== prev)
            $display("FAIL write_done: got dd=%0b rdata=%h expected dd=1 rdata=%h", d_done[0], d_rdata[0], prev);
        else n_pass++;
        ref_mem[0][64] = 32'hDEAD_BEEF;
        d_req[0] = 1'b0; d_we[0] = 1'b0;
        tick();
        d_req[0] = 1'b1; d_addr[0] = 32'h100;
        repeat (4) tick();
        n_total++;
        if (d_done[0] !== 1'b1 || d_rdata[0] !== 32'hDEAD_BEEF)
            $display("FAIL readback: got dd=%0b rdata=%h expected dd=1 rdata=deadbeef", d_done[0], d_rdata[0]);
        else n_pass++;
        d_req[0] = 1'b0;
        tick();
    endtask

    task automatic test_simultaneous();
        logic [31:0] exp_c;
        do_reset();
        i_req[0] = 1'b1; i_addr[0] = 32'h40;
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h100;
        for (int c = 1; c <= 10; c++) begin
            tick();
            n_total++;
            if (d_done[0] !== (c == 4) || i_done[0] !== (c == 9))
                $display("FAIL sim_done_t%0d: got dd=%0b id=%0b expected dd=%0b id=%0b", c, d_done[0], i_done[0], c == 4, c == 9);
            else n_pass++;
            if (c == 4) d_req[0] = 1'b0;
            if (c == 9) i_req[0] = 1'b0;
        end
        n_total++;
        if (d_rdata[0] !== ref_mem[0][64] || i_rdata[0] !== ref_mem[0][16])
            $display("FAIL sim_rdata: got d=%h i=%h expected d=%h i=%h", d_rdata[0], i_rdata[0], ref_mem[0][64], ref_mem[0][16]);
        else n_pass++;
`ifdef MEM_ARB_CONFLICT_COUNT_EN
        exp_c = 32'd1;
`else
        exp_c = 32'd0;
`endif
        n_total++;
        if (conflicts[0] !== exp_c) $display("FAIL sim_conflicts: got %0d expected %0d", conflicts[0], exp_c); else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        i_req[0] = 1'b1; i_addr[0] = 32'h40;
        repeat (4) tick();
        i_req[0] = 1'b0;
        tick();
        i_req[0] = 1'b1; d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'h300; d_wdata[0] = 32'h1357_9BDF;
        ref_mem[0][192] = 32'h1357_9BDF;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c == 4) begin d_req[0] = 1'b0; d_we[0] = 1'b0; end
        end
        reset = 1'b0;
        tick();
        n_total++;
        if ({mem_en[0], mem_we[0], i_done[0], d_done[0]} !== 4'b0 || mem_addr[0] !== 32'h0 ||
            mem_wdata[0] !== 32'h0 || i_rdata[0] !== 32'h0 || d_rdata[0] !== 32'h0 || conflicts[0] !== 32'h0)
            $display("FAIL reset_mid: got en=%0b id=%0b addr=%h wd=%h ird=%h conf=%0d expected all zero",
                     mem_en[0], i_done[0], mem_addr[0], mem_wdata[0], i_rdata[0], conflicts[0]);
        else n_pass++;
        i_req[0] = 1'b0;
        tick();
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_total++;
            if (i_done[0] !== 1'b0 || d_done[0] !== 1'b0 || mem_en[0] !== 1'b0)
                $display("FAIL reset_no_done_t%0d: got id=%0b dd=%0b en=%0b expected 0 0 0", c, i_done[0], d_done[0], mem_en[0]);
            else n_pass++;
        end
        i_req[0] = 1'b1; i_addr[0] = 32'h40;
        repeat (3) tick();
        n_total++;
        if (i_done[0] !== 1'b0) $display("FAIL post_reset_early: got %0b expected 0", i_done[0]); else n_pass++;
        tick();
        n_total++;
        if (i_done[0] !== 1'b1 || i_rdata[0] !== 32'h8C08_0004)
            $display("FAIL post_reset_fetch: got id=%0b rdata=%h expected id=1 rdata=8c080004", i_done[0], i_rdata[0]);
        else n_pass++;
        i_req[0] = 1'b0;
        tick();
    endtask

    task automatic test_early_drop();
        do_reset();
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h3F0;
        tick();
        tick();
        d_req[0] = 1'b0;
        tick();
        n_total++;
        if (d_done[0] !== 1'b0) $display("FAIL drop_early_done: got %0b expected 0", d_done[0]); else n_pass++;
        tick();
        n_total++;
        if (d_done[0] !== 1'b1 || d_rdata[0] !== ref_mem[0][252])
            $display("FAIL drop_done: got dd=%0b rdata=%h expected dd=1 rdata=%h", d_done[0], d_rdata[0], ref_mem[0][252]);
        else n_pass++;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_total++;
            if (mem_en[0] !== 1'b0 || d_done[0] !== 1'b0)
                $display("FAIL drop_no_reissue_t%0d: got en=%0b dd=%0b expected 0 0", c, mem_en[0], d_done[0]);
            else n_pass++;
        end
    endtask

    task automatic test_latency_sweep();
        for (int k = 1; k < N; k++) begin
            int en_cnt = 0;
            int en_first = -1;
            int done_at = -1;
            logic [31:0] got_rd = '0;
            logic [31:0] addr;
            do_reset();
            addr = $urandom() & 32'hFFFF_FFFC;
            i_req[k] = 1'b1; i_addr[k] = addr;
            for (int c = 1; c <= lat_of(k) + 6; c++) begin
                tick();
                if (mem_en[k] === 1'b1) begin
                    en_cnt++;
                    if (en_first < 0) en_first = c;
                end
                if (i_done[k] === 1'b1 && done_at < 0) begin
                    done_at = c; got_rd = i_rdata[k]; i_req[k] = 1'b0;
                end
            end
            i_req[k] = 1'b0;
            n_total++;
            if (done_at != lat_of(k) + 2)
                $display("FAIL sweep_lat%0d_done: got T+%0d expected T+%0d", lat_of(k), done_at, lat_of(k) + 2);
            else n_pass++;
            n_total++;
            if (en_cnt != 1 || en_first != 1)
                $display("FAIL sweep_lat%0d_en: got width=%0d first=T+%0d expected width=1 first=T+1", lat_of(k), en_cnt, en_first);
            else n_pass++;
            n_total++;
            if (got_rd !== ref_mem[k][addr[9:2]])
                $display("FAIL sweep_lat%0d_rdata: got %h expected %h", lat_of(k), got_rd, ref_mem[k][addr[9:2]]);
            else n_pass++;
        end
    endtask

    // Transaction-level model: an access granted at cycle t strobes memory at
    // t+1, completes at t+LAT+2 and frees the arbiter at t+LAT+3.
    task automatic test_random(input int k);
        int lat;
        int free_at = 0;
        int en_t = -1;
        int done_t = -1;
        int conf = 0;
        logic done_is_d = 1'b0;
        logic win_we = 1'b0;
        logic [31:0] win_addr = '0;
        logic [31:0] win_wdata = '0;
        logic [31:0] win_val = '0;
        logic [31:0] rd_i = '0;
        logic [31:0] rd_d = '0;
        logic i_fin, d_fin;
        lat = lat_of(k);
        do_reset();
        for (int t = 0; t < 300; t++) begin
            if (t == done_t && !win_we) begin
                if (done_is_d) rd_d = win_val; else rd_i = win_val;
            end
            n_total++;
            if (mem_en[k] !== (t == en_t) ||
                (t == en_t && (mem_addr[k] !== win_addr || mem_we[k] !== win_we || (win_we && mem_wdata[k] !== win_wdata))))
                $display("FAIL rnd%0d_mem_t%0d: got en=%0b addr=%h we=%0b wd=%h expected en=%0b addr=%h we=%0b wd=%h",
                         k, t, mem_en[k], mem_addr[k], mem_we[k], mem_wdata[k], t == en_t, win_addr, win_we, win_wdata);
            else n_pass++;
            i_fin = (t == done_t) && !done_is_d;
            d_fin = (t == done_t) && done_is_d;
            n_total++;
            if (i_done[k] !== i_fin || d_done[k] !== d_fin)
                $display("FAIL rnd%0d_done_t%0d: got id=%0b dd=%0b expected id=%0b dd=%0b", k, t, i_done[k], d_done[k], i_fin, d_fin);
            else n_pass++;
            n_total++;
            if (i_rdata[k] !== rd_i || d_rdata[k] !== rd_d)
                $display("FAIL rnd%0d_rdata_t%0d: got i=%h d=%h expected i=%h d=%h", k, t, i_rdata[k], d_rdata[k], rd_i, rd_d);
            else n_pass++;
            n_total++;
            if (conflicts[k] !== 32'(conf))
                $display("FAIL rnd%0d_conflicts_t%0d: got %0d expected %0d", k, t, conflicts[k], conf);
            else n_pass++;

            if (i_fin) i_req[k] = 1'b0;
            else if (!i_req[k] && $urandom_range(2) == 0) begin
                i_req[k] = 1'b1; i_addr[k] = $urandom() & 32'hFFFF_FFFC;
            end
            if (d_fin) d_req[k] = 1'b0;
            else if (!d_req[k] && $urandom_range(2) == 0) begin
                d_req[k] = 1'b1; d_we[k] = 1'($urandom_range(1));
                d_addr[k] = $urandom() & 32'hFFFF_FFFC; d_wdata[k] = $urandom();
            end

            if (t >= free_at && (i_req[k] || d_req[k])) begin
`ifdef MEM_ARB_CONFLICT_COUNT_EN
                if (i_req[k] && d_req[k]) conf++;
`endif
                done_is_d = d_req[k];
                win_addr  = d_req[k] ? d_addr[k] : i_addr[k];
                win_we    = d_req[k] && d_we[k];
                win_wdata = d_req[k] ? d_wdata[k] : 32'h0;
                if (win_we) ref_mem[k][win_addr[9:2]] = win_wdata;
                else        win_val = ref_mem[k][win_addr[9:2]];
                en_t    = t + 1;
                done_t  = t + lat + 2;
                free_at = t + lat + 3;
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        reset = 1'b0;
        pl_en = 1'b0; pl_idx = '0; pl_data = '0;
        clear_inputs();
        preload();
        test_reset();
        test_lone_fetch();
        test_write_read();
        test_simultaneous();
        test_reset_mid();
        test_early_drop();
        test_latency_sweep();
        for (int k = 0; k < N; k++) test_random(k);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
